// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host-transmit definitions: FSM state encoding, frame size, command bytes.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RELEASE,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERROR
  } tx_state_t;

  // Eight data bits, parity and stop. The start bit is the data-low request before the clock is released.
  localparam int FRAME_BITS = 10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises one open-collector PS/2 pad and debounces it.
// The output changes only after FILTER_LEN consecutive equal samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic line_filt
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] run_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the sync chain and the filtered level reset to 1, the pulled-up idle bus level.
      // A reset value of 0 would make a phantom clock fall appear right after reset.
      sync      <= 2'b11;
      run_cnt   <= '0;
      line_filt <= 1'b1;
    end else begin
      sync <= {sync[0], line_in};
      if (sync[1] == line_filt) begin
        run_cnt <= '0;
      end else if (run_cnt == CNT_W'(FILTER_LEN - 1)) begin
        line_filt <= sync[1];
        run_cnt   <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. It requests the bus, shifts out one command byte
// on the device-generated clock, and reports whether the device acked the byte.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_CYCLE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX     = 4'(FRAME_BITS - 1);

  tx_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic [3:0]            bit_idx;
  logic [FRAME_BITS-1:0] frame;
  logic                  clk_filt;
  logic                  data_filt;
  logic                  clk_filt_q;
  logic                  fall;
  logic                  timed_out;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_in   (ps2_clk_in),
    .line_filt (clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_in   (ps2_data_in),
    .line_filt (data_filt)
  );

  assign fall       = clk_filt_q & ~clk_filt;
  assign timed_out  = (cnt == TIMEOUT_LAST);
  assign rx_inhibit = tx_busy;

  // One counter serves two purposes. In INHIBIT it times how long the clock is held low.
  // From RELEASE onward it is the timeout for the whole device-paced part of the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      frame       <= '0;
      clk_filt_q  <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      // NOTE: every register in this block uses <=, so all decisions below see pre-edge values.
      // This is also why a later assignment to cnt in the same branch overrides an earlier one.
      clk_filt_q <= clk_filt;
      unique case (state)
        ST_IDLE: begin
          if (tx_req) begin
            frame       <= {1'b1, odd_parity(tx_data), tx_data};
            cnt         <= '0;
            bit_idx     <= '0;
            tx_busy     <= 1'b1;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= (INHIBIT_CYCLES == 1);
            state       <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == START_CYCLE) ps2_data_oe <= 1'b1;
          if (cnt == INHIBIT_LAST) begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= ST_RELEASE;
          end
        end

        ST_RELEASE, ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
          cnt <= cnt + 1'b1;
          if (timed_out) begin
            tx_error    <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= ST_ERROR;
          end else if (state == ST_RELEASE) begin
            state <= ST_SHIFT;
          end else if (state == ST_SHIFT) begin
            if (fall) begin
              ps2_data_oe <= ~frame[bit_idx];
              if (bit_idx == LAST_IDX) state <= ST_ACK;
              else bit_idx <= bit_idx + 1'b1;
            end
          end else if (state == ST_ACK) begin
            if (fall) begin
              if (data_filt) begin
                tx_error    <= 1'b1;
                ps2_data_oe <= 1'b0;
                state       <= ST_ERROR;
              end else begin
                state <= ST_WAIT_IDLE;
              end
            end
          end else if (clk_filt && data_filt) begin
            tx_done <= 1'b1;
            state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          tx_done <= 1'b0;
          tx_busy <= 1'b0;
          state   <= ST_IDLE;
        end

        ST_ERROR: begin
          tx_error <= 1'b0;
          tx_busy  <= 1'b0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx. A behavioural PS/2 device receives frames on the bus,
// and queued expectations are compared with the frames on the wire and the done/error pulses.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH  = 20;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  typedef enum bit {RES_DONE, RES_ERR} res_t;
  typedef enum logic [1:0] {DEV_ACK, DEV_NACK, DEV_SILENT} dev_mode_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_busy, tx_done, tx_error, rx_inhibit;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;

  logic [7:0] exp_bytes[$];
  res_t       exp_res[$];
  res_t       r;
  dev_mode_t  dev_mode;
  bit         dev_abort, dev_busy, chk_timeout, busy_next_chk, prev_clk_oe;
  logic [1:0] data_hist;
  int         dev_falls, cyc, rel_cyc, inh_run;
  int         n_checks, n_pass;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .rx_inhibit  (rx_inhibit),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic dev_wait(input int n);
    for (int k = 0; k < n && !dev_abort; k++) @(posedge clk);
  endtask

  // Device model: waits for a request-to-send, clocks 11 pulses, then acks or leaves data high.
  initial begin : device
    logic [9:0] bits;
    logic [7:0] eb;
    logic       exp_par;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    dev_busy     = 1'b0;
    dev_falls    = 0;
    forever begin
      @(negedge ps2_clk_oe);
      if (!reset_n) continue;
      dev_busy = 1'b1;
      check("start_bit", ps2_data_in, 1'b0);
      if (dev_mode != DEV_SILENT) begin
        dev_falls = 0;
        bits      = '0;
        dev_wait(10);
        for (int i = 0; i < 11 && !dev_abort; i++) begin
          if (i == 10 && dev_mode == DEV_ACK) begin
            dev_data_low = 1'b1;
            dev_wait(HALF / 2);
          end
          dev_clk_low = 1'b1;
          dev_falls++;
          dev_wait(HALF);
          if (i < 10) bits[i] = ps2_data_in;
          dev_clk_low = 1'b0;
          dev_wait(HALF);
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        if (!dev_abort) begin
          if (exp_bytes.size() == 0) begin
            check("unexpected_frame", {22'd0, bits}, 32'hFFFF_FFFF);
          end else begin
            eb      = exp_bytes.pop_front();
            exp_par = ($countones(eb) % 2 == 0);
            check("frame_data", bits[7:0], eb);
            check("parity", bits[8], exp_par);
            check("stop_bit", bits[9], 1'b1);
          end
        end
      end
      dev_busy = 1'b0;
    end
  end

  // Output monitor, sampled on the falling clock edge.
  initial begin
    cyc = 0; inh_run = 0; rel_cyc = 0; prev_clk_oe = 1'b0; busy_next_chk = 1'b0; data_hist = 2'b00;
  end

  always @(negedge clk) begin
    cyc++;
    if (ps2_clk_oe) begin
      inh_run++;
    end else begin
      if (prev_clk_oe && reset_n) begin
        check("inhibit_len", inh_run, INH);
        check("start_setup", data_hist, 2'b01);
        check("busy_during", {tx_busy, rx_inhibit}, 2'b11);
        rel_cyc = cyc;
      end
      inh_run = 0;
    end
    prev_clk_oe = ps2_clk_oe;
    data_hist   = {data_hist[0], ps2_data_oe};

    if (busy_next_chk) begin
      check("busy_after_end", {tx_busy, rx_inhibit}, 2'b00);
      busy_next_chk = 1'b0;
    end
    if (tx_done || tx_error) begin
      if (exp_res.size() == 0) begin
        check("unexpected_result", {tx_done, tx_error}, 2'b00);
      end else begin
        r = exp_res.pop_front();
        check("result", {tx_done, tx_error}, (r == RES_DONE) ? 2'b10 : 2'b01);
      end
      if (tx_error) check("oe_on_error", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      if (tx_error && chk_timeout) check("timeout_len", cyc - rel_cyc, TO);
      busy_next_chk = 1'b1;
    end
  end

  task automatic send(input logic [7:0] b, input bit expect_frame, input res_t res);
    @(negedge clk);
    tx_data = b;
    tx_req  = 1'b1;
    if (expect_frame) exp_bytes.push_back(b);
    exp_res.push_back(res);
    @(negedge clk);
    tx_req = 1'b0;
  endtask

  task automatic pulse_req(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_req  = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_res.size() != 0 || tx_busy || dev_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < budget), 1'b1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int n;
    n_checks = 0; n_pass = 0;
    reset_n = 1'b0; tx_req = 1'b0; tx_data = 8'h00;
    dev_mode = DEV_ACK; dev_abort = 1'b0; chk_timeout = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tx_busy, tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_data_oe}, 6'b0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    send(CMD_SET_LEDS, 1'b1, RES_DONE);
    wait_quiet("t1_led_cmd", 3000);

    send(8'h01, 1'b1, RES_DONE);
    wait_quiet("t2_parity0", 3000);
    send(CMD_RESET, 1'b1, RES_DONE);
    wait_quiet("t2_parity1", 3000);

    dev_mode = DEV_NACK;
    send(8'hA5, 1'b1, RES_ERR);
    wait_quiet("t3_nack", 3000);
    dev_mode = DEV_ACK;

    dev_mode    = DEV_SILENT;
    chk_timeout = 1'b1;
    send(CMD_SET_LEDS, 1'b0, RES_ERR);
    wait_quiet("t4_timeout", TO + INH + 200);
    chk_timeout = 1'b0;
    dev_mode    = DEV_ACK;

    send(CMD_ENABLE, 1'b1, RES_DONE);
    repeat (200) @(negedge clk);
    pulse_req(8'h55);
    wait_quiet("t5_busy_drop", 3000);

    dev_falls = 0;
    send(CMD_SET_LEDS, 1'b1, RES_DONE);
    n = 0;
    while (dev_falls < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_bit4", (n < 2000), 1'b1);
    repeat (20) @(negedge clk);
    dev_abort = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("t6_rst_busy", {tx_busy, rx_inhibit, tx_done, tx_error}, 4'b0);
    exp_bytes.delete();
    exp_res.delete();
    n = 0;
    while (dev_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t6_dev_abort", (n < 1000), 1'b1);
    repeat (5) @(negedge clk);
    dev_abort = 1'b0;
    reset_n   = 1'b1;
    repeat (20) @(negedge clk);
    send(CMD_SET_LEDS, 1'b1, RES_DONE);
    wait_quiet("t6_after_reset", 3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
